// File: rtl/fifo_reader.sv
// Read-side burst engine for the synchronous fifo: pops a programmed number of
// words and presents them on a valid/ready stream through a 2-entry skid buffer.
module fifo_reader #(
  parameter int DATA_SIZE = 8,
  parameter int LEN_SIZE  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_SIZE-1:0]  burst_len,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  input  logic                 fifo_underflow,
  output logic                 fifo_pop,
  output logic                 m_valid,
  output logic [DATA_SIZE-1:0] m_data,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_SIZE-1:0]  word_count,
  output logic                 underflow_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [LEN_SIZE-1:0] LEN_ONE = LEN_SIZE'(1);

  state_t               state;
  state_t               state_nxt;
  logic [LEN_SIZE-1:0]  pops_left;
  logic                 inflight;
  logic [1:0]           occ;
  logic [DATA_SIZE-1:0] buf_head;
  logic [DATA_SIZE-1:0] buf_tail;
  logic                 xfer;
  logic                 start_ok;
  logic [2:0]           level;

  assign xfer     = m_valid && m_ready;
  assign start_ok = (state == IDLE) && start;
  // Buffer slots still claimed after this cycle's handshake; never exceeds 2.
  assign level    = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (burst_len == '0) ? DONE : RUN;
      end
      RUN: begin
        fifo_pop = (pops_left != '0) && !fifo_empty && (level < 3'd2);
        if (fifo_pop && (pops_left == LEN_ONE)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave as the last word is handshaked so done lands one cycle later.
        if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && xfer))) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pops_left     <= '0;
      inflight      <= 1'b0;
      word_count    <= '0;
      underflow_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_pop;

      if (start_ok) pops_left <= burst_len;
      else if (fifo_pop) pops_left <= pops_left - LEN_ONE;

      if (start_ok) word_count <= '0;
      else if (xfer) word_count <= word_count + LEN_ONE;

      if (start_ok) underflow_err <= 1'b0;
      else if (busy && fifo_underflow) underflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      case ({inflight, xfer})
        2'b01: begin
          buf_head <= buf_tail;
          occ      <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) buf_head <= fifo_data;
          else buf_tail <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf_head <= fifo_data;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_head;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a behavioural fifo feeds the DUT and every
// output is compared against hand-derived cycle expectations.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] burst_len;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_underflow;
  logic       fifo_pop;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       busy;
  logic       done;
  logic [3:0] word_count;
  logic       underflow_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:63];
  int wr = 0;
  int rd = 0;

  fifo_reader #(.DATA_SIZE(8), .LEN_SIZE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_underflow(fifo_underflow),
    .fifo_pop(fifo_pop), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .done(done), .word_count(word_count), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // Source fifo: read data appears in the cycle after the pop.
  assign fifo_empty = (wr == rd);
  always @(posedge clk) begin
    if (fifo_pop === 1'b1) begin
      fifo_data <= mem[rd % 64];
      rd <= rd + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr % 64] = v;
    wr = wr + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pop"},   {31'd0, fifo_pop},      0);
    check({tag, "_valid"}, {31'd0, m_valid},       0);
    check({tag, "_data"},  {24'd0, m_data},        0);
    check({tag, "_busy"},  {31'd0, busy},          0);
    check({tag, "_done"},  {31'd0, done},          0);
    check({tag, "_count"}, {28'd0, word_count},    0);
    check({tag, "_uflow"}, {31'd0, underflow_err}, 0);
  endtask

  task automatic do_start(input logic [3:0] len);
    burst_len = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Consume a burst with the given per-cycle ready pattern, scoreboarding data
  // order, stall stability and the skid-buffer occupancy bound until done.
  task automatic drain(input string tag, input int n, input int first, input logic [31:0] rdy);
    int got;
    int expv;
    bit seen;
    bit stalled;
    logic [7:0] held;
    got = 0;
    expv = first;
    seen = 0;
    stalled = 0;
    held = 8'h00;
    for (int k = 0; k < 60 && !seen; k++) begin
      m_ready = (k < 32) ? rdy[k] : 1'b1;
      if (stalled) begin
        check({tag, "_hold_valid"}, {31'd0, m_valid}, 1);
        check({tag, "_hold_data"}, {24'd0, m_data}, {24'd0, held});
      end
      check({tag, "_occ_bound"}, {31'd0, (dut.occ + dut.inflight) <= 2}, 1);
      if (m_valid && m_ready) begin
        check({tag, "_data"}, {24'd0, m_data}, expv);
        expv++;
        got++;
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      if (done) begin
        seen = 1;
        check({tag, "_words"}, got, n);
        check({tag, "_count"}, {28'd0, word_count}, n);
      end else begin
        step();
      end
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 1);
    m_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    burst_len = 4'd0;
    fifo_underflow = 1'b0;
    m_ready = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Full-rate burst of 8
    for (int i = 0; i < 8; i++) push(8'(i));
    do_start(4'd8);
    for (int k = 1; k <= 12; k++) begin
      check("t1_pop", {31'd0, fifo_pop}, (k <= 8) ? 1 : 0);
      check("t1_valid", {31'd0, m_valid}, (k >= 3 && k <= 10) ? 1 : 0);
      if (k >= 3 && k <= 10) check("t1_data", {24'd0, m_data}, k - 3);
      check("t1_done", {31'd0, done}, (k == 11) ? 1 : 0);
      if (k == 11) check("t1_count", {28'd0, word_count}, 8);
      if (k < 12) step();
    end
    check("t1_busy_drop", {31'd0, busy}, 0);
    step();

    // Backpressure: 3-cycle stall then 1/0 toggling
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    do_start(4'd6);
    drain("t2", 6, 8'h10, 32'hFFFF_FA8F);
    step();

    // Empty fifo holds RUN
    do_start(4'd4);
    for (int k = 0; k < 10; k++) begin
      check("t3_pop", {31'd0, fifo_pop}, 0);
      check("t3_busy", {31'd0, busy}, 1);
      step();
    end
    check("t3_uflow", {31'd0, underflow_err}, 0);
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    drain("t3", 4, 8'h20, 32'hFFFF_FFFF);
    step();

    // Zero length
    do_start(4'd0);
    check("t4_done", {31'd0, done}, 1);
    check("t4_pop", {31'd0, fifo_pop}, 0);
    check("t4_count", {28'd0, word_count}, 0);
    step();
    check("t4_done_clear", {31'd0, done}, 0);
    check("t4_busy", {31'd0, busy}, 0);
    step();

    // Start while busy is ignored
    for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
    do_start(4'd6);
    burst_len = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t5_pops_left", {28'd0, dut.pops_left}, 5);
    check("t5_count", {28'd0, word_count}, 0);
    drain("t5", 6, 8'h30, 32'hFFFF_FFFF);
    step();

    // Reset mid-burst: pops in cycles s+1..s+4 take 0x40..0x43
    for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
    do_start(4'd6);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    step();
    do_start(4'd2);
    drain("t6", 2, 8'h44, 32'hFFFF_FFFF);
    step();

    // Sticky underflow flag
    for (int i = 0; i < 3; i++) push(8'(8'h50 + i));
    do_start(4'd3);
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    check("t7_uflow_set", {31'd0, underflow_err}, 1);
    drain("t7", 3, 8'h50, 32'hFFFF_FFFF);
    step();
    check("t7_uflow_hold", {31'd0, underflow_err}, 1);
    check("t7_idle", {31'd0, busy}, 0);
    push(8'h60);
    do_start(4'd1);
    check("t7_uflow_clear", {31'd0, underflow_err}, 0);
    drain("t7b", 1, 8'h60, 32'hFFFF_FFFF);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side engine for the team's synchronous `fifo` (push/pop, full/empty, overflow/underflow). On a `start` command it pops a programmed number of words from the FIFO and presents them on a valid/ready output stream. It never pops an empty FIFO, and it absorbs downstream backpressure in a 2-entry output buffer. It sits between the FIFO's pop port and any downstream consumer.

## Interface

**Parameters**

- `DATA_SIZE`, default 8: word width; matches the FIFO.
- `LEN_SIZE`, default 4: width of the burst length and word counter; max burst is 2**LEN_SIZE-1.

**Ports**

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle command pulse; accepted only in IDLE.
- `burst_len` input LEN_SIZE: words to read; sampled when `start` is accepted.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_data` input DATA_SIZE: FIFO read data; valid in the cycle after `fifo_pop`.
- `fifo_underflow` input 1: FIFO underflow flag.
- `fifo_pop` output 1: pop request to the FIFO; combinational from registered state, `fifo_empty` and `m_ready`.
- `m_valid` output 1: output word valid.
- `m_data` output DATA_SIZE: output word.
- `m_ready` input 1: downstream accepts the word; transfer happens when `m_valid && m_ready`.
- `busy` output 1: high in any state except IDLE.
- `done` output 1: one-cycle pulse when the burst completes.
- `word_count` output LEN_SIZE: words transferred on `m_*` in the current or last burst.
- `underflow_err` output 1: sticky; set if `fifo_underflow` is seen while busy.

## Operation

**States**

- IDLE: waits for `start`. On `start`:
  - load `pops_left = burst_len`.
  - clear `word_count` and `underflow_err`.
  - go to RUN, or to DONE if `burst_len == 0`.
- RUN: issues pops. When the last pop is issued (`pops_left` 1→0), go to DRAIN.
- DRAIN: waits until the in-flight read has landed and the buffer is empty (all `burst_len` words handshaked), then goes to DONE.
- DONE: asserts `done = 1` for exactly one cycle, then goes to IDLE.

**Pop rule (RUN only)**

- `fifo_pop = (pops_left != 0) && !fifo_empty && (occ + inflight - (m_valid && m_ready) < 2)`.
  - `occ` is buffer occupancy (0..2).
  - `inflight` is a register holding the previous cycle's `fifo_pop`.
- Invariant: `occ + inflight <= 2`.
- `fifo_pop` is never asserted while `fifo_empty = 1`, so the FIFO never underflows due to this block.

**Data path**

- When `inflight = 1`, `fifo_data` is written into the buffer tail at the end of that cycle.
- `m_data` is the buffer head, `m_valid = (occ != 0)`.
- Buffer is FIFO-ordered; no word is lost or duplicated.

**Counters**

- `word_count` increments on each output handshake.
- `pops_left` decrements on each pop.
- Both are LEN_SIZE bits and never wrap within a legal burst.

**Other rules**

- `start` while busy is ignored. `burst_len` is not re-sampled.
- `underflow_err` is set on any cycle with `busy && fifo_underflow`. It holds until the next accepted `start` or `rst`.
- `rst` in any state, including mid-burst:
  - next cycle is IDLE.
  - buffer, `inflight` and `pops_left` are cleared.
  - words in flight are discarded.

## Timing

**Reset values:** `fifo_pop = 0`, `m_valid = 0`, `m_data = 0`, `busy = 0`, `done = 0`, `word_count = 0`, `underflow_err = 0`.

**Latency**

- `start` sampled at edge s → RUN and `busy = 1` in cycle s+1.
- First `fifo_pop` can assert in cycle s+1.
- A pop in cycle c → data captured at the end of c+1 → `m_valid = 1` in cycle c+2.
- Pop-to-output latency is 2 cycles.

**Throughput:** 1 word/cycle with `m_ready = 1` and a non-empty FIFO.

**Stall behaviour**

- While `m_valid && !m_ready`, `m_data` and `m_valid` are held stable.
- Pops stop once `occ + inflight` reaches 2.

**Completion:** `done` pulses in the cycle after the final handshake. `busy` drops in the cycle after `done`.

**Empty FIFO:** RUN holds indefinitely while `fifo_empty = 1`, with no timeout.

## Test plan

- **Full-rate burst.** FIFO preloaded with 8 words 0..7, `burst_len = 8`, `m_ready = 1`.
  - `fifo_pop` high for 8 consecutive cycles starting at s+1.
  - `m_data` = 0..7 on consecutive cycles starting at s+3.
  - `done` pulses one cycle after the last handshake, then `word_count = 8`.
- **Backpressure.** `burst_len = 6`; `m_ready` held low for 3 cycles mid-burst, then toggled 1/0.
  - Output sequence is exactly the FIFO order, with no loss or duplicates.
  - `m_data` is stable while stalled.
  - `occ + inflight` never exceeds 2.
- **Empty FIFO.** `burst_len = 4` with FIFO empty for 10 cycles.
  - `fifo_pop` stays 0 and `busy` stays 1; `underflow_err` stays 0.
  - After 4 words are pushed, 4 words are output and `done` pulses.
- **Zero length.** `burst_len = 0`: `done = 1` in cycle s+1 with no `fifo_pop`, and `word_count = 0`.
- **Ignored start and mid-burst reset.**
  - A `start` pulsed mid-burst does not change `pops_left` or `word_count`.
  - `rst` asserted mid-burst puts all outputs at reset values on the next cycle; a new `start` then runs cleanly.
- **Underflow flag.** Force `fifo_underflow = 1` for one cycle while busy.
  - `underflow_err` goes to 1 and stays 1 after `done`.
  - The next accepted `start` clears it.
